// File: rtl/aes_dec_pkg.sv
// rtl/aes_dec_pkg.sv - shared AES decryption datapath types and helpers
package aes_dec_pkg;

  localparam int STATE_W = 128;
  localparam int BYTE_W  = 8;

  typedef enum logic [1:0] {
    ISB_IDLE = 2'd0,
    ISB_BUSY = 2'd1,
    ISB_DONE = 2'd2
  } isb_state_t;

  // Byte i of a state word (FIPS-197 column-major order) has its MSB at 127-8i.
  function automatic int byte_msb(input int i);
    return STATE_W - 1 - BYTE_W * i;
  endfunction

endpackage

// File: rtl/inv_sub_bytes_seq_if.sv
// rtl/inv_sub_bytes_seq_if.sv - valid/ready state-word bundle for the InvSubBytes stage
interface inv_sub_bytes_seq_if;
  import aes_dec_pkg::*;

  logic               in_valid;
  logic               in_ready;
  logic [STATE_W-1:0] din;
  logic               out_valid;
  logic               out_ready;
  logic [STATE_W-1:0] dout;

  // Stage side: consumes din, produces dout.
  modport slave (
    input  in_valid, din, out_ready,
    output in_ready, out_valid, dout
  );

  // Neighbour side: drives din and out_ready, observes the stage outputs.
  modport master (
    output in_valid, din, out_ready,
    input  in_ready, out_valid, dout
  );

endinterface

// File: rtl/dsoftbox.sv
// rtl/dsoftbox.sv - combinational AES inverse S-box lookup
module dsoftbox (
  input  logic [7:0] din,
  output logic [7:0] dout
);

  // Entry 0 is the leftmost byte; each 128-bit row covers 16 consecutive inputs.
  localparam logic [0:255][7:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  assign dout = INV_SBOX[din];

endmodule

// File: rtl/inv_sub_bytes_seq.sv
// rtl/inv_sub_bytes_seq.sv - sequential InvSubBytes stage, LANES bytes per cycle
module inv_sub_bytes_seq
  import aes_dec_pkg::*;
#(
  parameter int LANES = 4
) (
  input  logic                clk,
  input  logic                rst,
  inv_sub_bytes_seq_if.slave  bus
);

  localparam int NBYTES = STATE_W / BYTE_W;
  localparam int NPASS  = NBYTES / LANES;
  localparam int PASS_W = (NPASS > 1) ? $clog2(NPASS) : 1;

  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
    $error("inv_sub_bytes_seq: LANES must be 1, 2, 4, 8 or 16");
  end

  isb_state_t         state_q, state_d;
  logic [PASS_W-1:0]  pass_q;
  logic [STATE_W-1:0] st_q;
  logic [STATE_W-1:0] st_sub;
  logic               load;
  logic               step;
  logic               last_pass;
  logic               in_ready_c;
  logic               out_valid_c;
  logic [BYTE_W-1:0]  lane_in  [LANES];
  logic [BYTE_W-1:0]  lane_out [LANES];

  assign last_pass = (pass_q == PASS_W'(NPASS - 1));

  // Lane k looks up byte pass*LANES+k of the state in flight.
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    assign lane_in[k] = st_q[byte_msb(int'(pass_q) * LANES + k) -: BYTE_W];

    dsoftbox u_sbox (
      .din  (lane_in[k]),
      .dout (lane_out[k])
    );
  end

  // Merge this pass's substituted bytes back into the state; other bytes pass through.
  always_comb begin
    st_sub = st_q;
    for (int k = 0; k < LANES; k++) begin
      st_sub[byte_msb(int'(pass_q) * LANES + k) -: BYTE_W] = lane_out[k];
    end
  end

  // Next-state, load/step strobes and handshake outputs.
  always_comb begin
    state_d     = state_q;
    load        = 1'b0;
    step        = 1'b0;
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    unique case (state_q)
      ISB_IDLE: begin
        in_ready_c = ~rst;
        if (bus.in_valid) begin
          load    = 1'b1;
          state_d = ISB_BUSY;
        end
      end
      ISB_BUSY: begin
        step = 1'b1;
        if (last_pass) begin
          state_d = ISB_DONE;
        end
      end
      ISB_DONE: begin
        out_valid_c = 1'b1;
        in_ready_c  = ~rst & bus.out_ready;
        if (bus.out_ready) begin
          if (bus.in_valid) begin
            load    = 1'b1;
            state_d = ISB_BUSY;
          end else begin
            state_d = ISB_IDLE;
          end
        end
      end
      default: begin
        state_d = ISB_IDLE;
      end
    endcase
  end

  // State, pass counter and state word; reset discards anything in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ISB_IDLE;
      pass_q  <= '0;
      st_q    <= '0;
    end else begin
      state_q <= state_d;
      if (load) begin
        st_q   <= bus.din;
        pass_q <= '0;
      end else if (step) begin
        st_q   <= st_sub;
        pass_q <= last_pass ? '0 : pass_q + PASS_W'(1);
      end
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.dout      = st_q;

endmodule

// File: tb/tb_inv_sub_bytes_seq.sv
// tb/tb_inv_sub_bytes_seq.sv - directed-vector bench for inv_sub_bytes_seq
module tb_inv_sub_bytes_seq;

  localparam logic [127:0] KNOWN_IN  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] KNOWN_OUT = 128'h52096ad53036a538bf40a39e81f3d7fb;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  inv_sub_bytes_seq_if bus ();

  inv_sub_bytes_seq #(.LANES(4)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Lane-count sweep instances share clk/rst and a common input, out_ready tied high.
  logic         sw_in_valid = 1'b0;
  logic [127:0] sw_din      = '0;
  logic         sw_valid [4];
  logic [127:0] sw_dout  [4];

  for (genvar j = 0; j < 4; j++) begin : g_sw
    localparam int L = (j == 0) ? 1 : (j == 1) ? 2 : (j == 2) ? 8 : 16;
    inv_sub_bytes_seq_if sw_if ();
    assign sw_if.in_valid  = sw_in_valid;
    assign sw_if.din       = sw_din;
    assign sw_if.out_ready = 1'b1;
    inv_sub_bytes_seq #(.LANES(L)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (sw_if.slave)
    );
    assign sw_valid[j] = sw_if.out_valid;
    assign sw_dout[j]  = sw_if.dout;
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(output int cnt);
    cnt = 0;
    while (!bus.out_valid && cnt < 50) begin
      tick();
      cnt++;
    end
  endtask

  // Offer d in a cycle where the stage is ready, then measure latency and result.
  task automatic run_vec(input string tag, input logic [127:0] d, input logic [127:0] exp);
    int cnt;
    bus.in_valid = 1'b1;
    bus.din      = d;
    check({tag, "_rdy"}, bus.in_ready, 1'b1);
    tick();
    bus.in_valid = 1'b0;
    bus.din      = '0;
    wait_valid(cnt);
    check({tag, "_lat"}, cnt, 4);
    check({tag, "_dout"}, bus.dout, exp);
    tick();
  endtask

  initial begin
    int  cnt;
    bit  seen;
    int  lat [4];
    logic [127:0] got [4];
    int  exp_lat [4];
    exp_lat = '{16, 8, 2, 1};

    bus.in_valid  = 1'b1;
    bus.din       = KNOWN_IN;
    bus.out_ready = 1'b1;
    rst = 1'b1;
    repeat (3) tick();
    check("rst_in_ready", bus.in_ready, 1'b0);
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_dout", bus.dout, '0);
    rst = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    check("idle_in_ready", bus.in_ready, 1'b1);

    run_vec("known", KNOWN_IN, KNOWN_OUT);
    run_vec("all63", {16{8'h63}}, {16{8'h00}});
    run_vec("allD4", {16{8'hd4}}, {16{8'h19}});
    run_vec("all7C", {16{8'h7c}}, {16{8'h01}});
    run_vec("all16", {16{8'h16}}, {16{8'hff}});

    // Backpressure: first result held while a second state waits.
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.din       = KNOWN_IN;
    tick();
    bus.din = {16{8'hd4}};
    wait_valid(cnt);
    check("bp_lat", cnt, 4);
    for (int i = 0; i < 5; i++) begin
      check("bp_hold_valid", bus.out_valid, 1'b1);
      check("bp_hold_dout", bus.dout, KNOWN_OUT);
      check("bp_hold_rdy", bus.in_ready, 1'b0);
      tick();
    end
    bus.out_ready = 1'b1;
    #1;
    check("bp_release_rdy", bus.in_ready, 1'b1);
    tick();
    bus.in_valid = 1'b0;
    check("bp_handoff_valid", bus.out_valid, 1'b0);
    wait_valid(cnt);
    check("bp_second_lat", cnt, 4);
    check("bp_second_dout", bus.dout, {16{8'h19}});
    tick();

    // Reset two cycles into BUSY drops the state in flight.
    bus.in_valid = 1'b1;
    bus.din      = {16{8'h55}};
    tick();
    bus.in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("midrst_idle_rdy", bus.in_ready, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (bus.out_valid) seen = 1'b1;
      tick();
    end
    check("midrst_no_valid", seen, 1'b0);
    run_vec("after_rst", {16{8'h00}}, {16{8'h52}});

    // Lane-count sweep: same result, latency 16/LANES.
    for (int j = 0; j < 4; j++) begin
      lat[j] = 0;
      got[j] = '0;
    end
    sw_in_valid = 1'b1;
    sw_din      = KNOWN_IN;
    tick();
    sw_in_valid = 1'b0;
    sw_din      = '0;
    for (int c = 0; c <= 24; c++) begin
      for (int j = 0; j < 4; j++) begin
        if (sw_valid[j] && lat[j] == 0) begin
          lat[j] = c;
          got[j] = sw_dout[j];
        end
      end
      tick();
    end
    for (int j = 0; j < 4; j++) begin
      check($sformatf("sweep%0d_lat", exp_lat[j]), lat[j], exp_lat[j]);
      check($sformatf("sweep%0d_dout", exp_lat[j]), got[j], KNOWN_OUT);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
